hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Next-gen pipeline hazard unit: EX forwarding, load-use/branch stalls, load->store bypass, plus a
//  one-entry scoreboard for a multi-cycle mul/div unit (MDU) issuing from EX. Sits beside the 5-stage
//  datapath; drives forwarding muxes and StallF/StallD/FlushE.
// PARAMETERS
//  RA_W        5  register address width (register 0 hardwired zero)
//  MD_LATENCY  4  MDU cycles from issue to result (legal 2..15)
//  CNT_W       4  countdown width; must hold MD_LATENCY-1
// PORTS
//  clk           in  1     clock
//  rst           in  1     synchronous active-high reset
//  id_rs_a/id_rt_a  in RA_W  ID sources; id_branch in 1; id_md in 1 (MDU op in ID)
//  ex_rs_a/ex_rt_a/ex_rd_a in RA_W; ex_RegWrite, ex_MemToReg, ex_md_start in 1 (MDU op issuing, EX valid)
//  mem_rd_a in RA_W; mem_RegWrite, mem_MemToReg, mem_MemWrite in 1
//  wb_rd_a in RA_W; wb_RegWrite, wb_MemToReg in 1
//  md_cancel     in  1     kill in-flight MDU op (exception)
//  ex_forward_a/ex_forward_b out 2  00 reg, 01 WB, 10 MEM ALU, 11 MDU result
//  StallF, StallD, FlushE, LoadStore out 1
//  md_busy out 1; md_done out 1 (one-cycle result-valid pulse); md_rd_a out RA_W (MDU dest)
// BEHAVIOUR
//  - State: busy_q, cnt_q[CNT_W], rd_q[RA_W]. rst: all 0 -> md_busy=0, md_done=0, md_rd_a=0.
//  - Issue: ex_md_start && !FlushE-gating n/a (EX already valid): busy_q<=1, cnt_q<=MD_LATENCY-1, rd_q<=ex_rd_a.
//  - Busy: cnt_q decrements each cycle; md_done = busy_q && cnt_q==0 (comb); next cycle busy_q<=0
//    unless a new issue same cycle (back-to-back allowed: issue wins, reloads counter/rd).
//  - md_cancel: busy_q<=0 next cycle, md_done forced 0 that cycle; cancel+issue same cycle -> issue wins.
//  - Forwarding (priority high->low): MDU (md_done, rd_q!=0, rd_q==ex_rX) 11; MEM ALU
//    (mem_RegWrite && !mem_MemToReg && rd!=0 && match) 10; WB (wb_RegWrite && rd!=0 && match) 01; else 00.
//  - LoadStore = mem_MemWrite && wb_MemToReg && mem_rd_a!=0 && mem_rd_a==wb_rd_a.
//  - load_use = ex_MemToReg && !LoadStore && (id_rs_a or id_rt_a nonzero and == ex_rd_a).
//  - branch_hz = id_branch && src!=0 && ((ex_RegWrite && src==ex_rd_a) || (mem_RegWrite && src==mem_rd_a)
//    || (busy_q && src==rd_q)).
//  - md_raw = busy_q && !md_done && (id_rs_a or id_rt_a nonzero and == rd_q): source still pending.
//  - md_struct = id_md && busy_q && !md_done (second MDU op waits; issues on done cycle at earliest).
//  - StallF = StallD = FlushE = load_use | branch_hz | md_raw | md_struct. Zero-latency comb paths.
//  - Register 0 never causes a stall or forward; rd_q==0 op still occupies MDU (md_struct applies).
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds outputs perf_stall_cycles[31:0], perf_md_stalls[31:0]; increment
//   on StallF and on (md_raw|md_struct) respectively; saturate at 32'hFFFF_FFFF; cleared by rst.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package hazard_pkg: fwd_sel_t enum (FWD_REG=00, FWD_WB=01, FWD_MEM=10, FWD_MDU=11), RA_W.
//  One sub-module md_scoreboard (busy/cnt/rd state, md_done, md_raw, md_struct); top holds comb logic.
// TESTING
//  1 ex_md_start rd=5, MD_LATENCY=4 -> md_busy 4 cycles, md_done on 4th only, id_rs_a=5 stalls cycles 1-3.
//  2 md_done with ex_rs_a=5, mem_rd_a=5 ALU write -> ex_forward_a=11 (MDU beats MEM).
//  3 id_md while busy -> stall until done cycle; issue on done cycle -> busy stays 1, cnt reloads to 3, rd_q updates.
//  4 md_cancel at cycle 2 -> busy 0 next cycle, md_done never pulses, id_rs_a=5 stall released.
//  5 lw r3 in MEM (wb), sw r3 in MEM: LoadStore=1; ex lw r4, id uses r4 -> StallF=FlushE=1; r0 use -> no stall.
//  6 rst asserted mid-op -> md_busy=0, md_done=0, stalls from scoreboard drop next edge; perf counters 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard unit and its MDU scoreboard.
package hazard_pkg;

    localparam int RA_W = 5;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_MDU = 2'b11
    } fwd_sel_t;

    // Register 0 is hardwired zero, so it never matches a producer.
    function automatic logic src_hit(input logic [RA_W-1:0] src, input logic [RA_W-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/md_scoreboard.sv
// One-entry scoreboard for the multi-cycle MDU: tracks the in-flight op,
// raises md_done on its result cycle and flags dependent or structural hazards in ID.
import hazard_pkg::*;

module md_scoreboard #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_md_start,
    input  logic [RA_W-1:0] ex_rd_a,
    input  logic            md_cancel,
    input  logic [RA_W-1:0] id_rs_a,
    input  logic [RA_W-1:0] id_rt_a,
    input  logic            id_md,
    output logic            busy,
    output logic            done,
    output logic [RA_W-1:0] rd,
    output logic            md_raw,
    output logic            md_struct
);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [RA_W-1:0]  rd_q;
    logic             pending;

    // A cancel on the final cycle suppresses the result pulse.
    assign done    = busy_q && (cnt_q == '0) && !md_cancel;
    assign pending = busy_q && !done;

    assign busy      = busy_q;
    assign rd        = rd_q;
    assign md_raw    = pending && (src_hit(id_rs_a, rd_q) || src_hit(id_rt_a, rd_q));
    assign md_struct = id_md && pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rd_q   <= '0;
        end else if (ex_md_start) begin
            // A new issue beats both cancel and natural completion.
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(MD_LATENCY - 1);
            rd_q   <= ex_rd_a;
        end else if (md_cancel) begin
            busy_q <= 1'b0;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: EX forwarding, load-use/branch/MDU stalls and load->store bypass.
// Defining HAZARD_PERF_CNT_EN adds saturating stall performance counters.
import hazard_pkg::*;

module hazard_scoreboard #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] id_rs_a,
    input  logic [RA_W-1:0] id_rt_a,
    input  logic            id_branch,
    input  logic            id_md,
    input  logic [RA_W-1:0] ex_rs_a,
    input  logic [RA_W-1:0] ex_rt_a,
    input  logic [RA_W-1:0] ex_rd_a,
    input  logic            ex_RegWrite,
    input  logic            ex_MemToReg,
    input  logic            ex_md_start,
    input  logic [RA_W-1:0] mem_rd_a,
    input  logic            mem_RegWrite,
    input  logic            mem_MemToReg,
    input  logic            mem_MemWrite,
    input  logic [RA_W-1:0] wb_rd_a,
    input  logic            wb_RegWrite,
    input  logic            wb_MemToReg,
    input  logic            md_cancel,
    output logic [1:0]      ex_forward_a,
    output logic [1:0]      ex_forward_b,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushE,
    output logic            LoadStore,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_md_stalls,
`endif
    output logic            md_busy,
    output logic            md_done,
    output logic [RA_W-1:0] md_rd_a
);

    logic md_raw;
    logic md_struct;

    md_scoreboard #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .ex_md_start (ex_md_start),
        .ex_rd_a     (ex_rd_a),
        .md_cancel   (md_cancel),
        .id_rs_a     (id_rs_a),
        .id_rt_a     (id_rt_a),
        .id_md       (id_md),
        .busy        (md_busy),
        .done        (md_done),
        .rd          (md_rd_a),
        .md_raw      (md_raw),
        .md_struct   (md_struct)
    );

    function automatic fwd_sel_t fwd_pick(
        input logic [RA_W-1:0] src,
        input logic            mdu_ok,
        input logic [RA_W-1:0] mdu_rd,
        input logic            mem_alu,
        input logic [RA_W-1:0] mem_rd,
        input logic            wb_wr,
        input logic [RA_W-1:0] wb_rd
    );
        if (mdu_ok && src_hit(src, mdu_rd))       return FWD_MDU;
        else if (mem_alu && src_hit(src, mem_rd)) return FWD_MEM;
        else if (wb_wr && src_hit(src, wb_rd))    return FWD_WB;
        else                                      return FWD_REG;
    endfunction

    logic [RA_W-1:0] ex_src [2];
    logic [RA_W-1:0] id_src [2];
    logic [1:0][1:0] fwd_vec;
    logic [1:0]      load_use_src;
    logic [1:0]      branch_src;

    assign ex_src[0] = ex_rs_a;
    assign ex_src[1] = ex_rt_a;
    assign id_src[0] = id_rs_a;
    assign id_src[1] = id_rt_a;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign fwd_vec[gi] = fwd_pick(ex_src[gi], md_done, md_rd_a,
                                          mem_RegWrite && !mem_MemToReg, mem_rd_a,
                                          wb_RegWrite, wb_rd_a);
            assign load_use_src[gi] = src_hit(id_src[gi], ex_rd_a);
            // The MDU term uses busy rather than pending: the result is not yet
            // on the branch compare path even on the done cycle.
            assign branch_src[gi] = (ex_RegWrite  && src_hit(id_src[gi], ex_rd_a))
                                 || (mem_RegWrite && src_hit(id_src[gi], mem_rd_a))
                                 || (md_busy      && src_hit(id_src[gi], md_rd_a));
        end
    endgenerate

    assign ex_forward_a = fwd_vec[0];
    assign ex_forward_b = fwd_vec[1];

    assign LoadStore = mem_MemWrite && wb_MemToReg && (mem_rd_a != '0) && (mem_rd_a == wb_rd_a);

    logic load_use;
    logic branch_hz;
    logic stall;

    assign load_use  = ex_MemToReg && !LoadStore && (|load_use_src);
    assign branch_hz = id_branch && (|branch_src);
    assign stall     = load_use | branch_hz | md_raw | md_struct;

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_md_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_reg <= '0;
            perf_md_reg    <= '0;
        end else begin
            if (stall && (perf_stall_reg != 32'hFFFF_FFFF))
                perf_stall_reg <= perf_stall_reg + 32'd1;
            if ((md_raw || md_struct) && (perf_md_reg != 32'hFFFF_FFFF))
                perf_md_reg <= perf_md_reg + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_reg;
    assign perf_md_stalls    = perf_md_reg;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs_a, id_rt_a, ex_rs_a, ex_rt_a, ex_rd_a, mem_rd_a, wb_rd_a;
    logic       id_branch, id_md, ex_RegWrite, ex_MemToReg, ex_md_start;
    logic       mem_RegWrite, mem_MemToReg, mem_MemWrite, wb_RegWrite, wb_MemToReg, md_cancel;
    logic [1:0] ex_forward_a, ex_forward_b;
    logic       StallF, StallD, FlushE, LoadStore, md_busy, md_done;
    logic [4:0] md_rd_a;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_md_stalls;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst),
        .id_rs_a(id_rs_a), .id_rt_a(id_rt_a), .id_branch(id_branch), .id_md(id_md),
        .ex_rs_a(ex_rs_a), .ex_rt_a(ex_rt_a), .ex_rd_a(ex_rd_a),
        .ex_RegWrite(ex_RegWrite), .ex_MemToReg(ex_MemToReg), .ex_md_start(ex_md_start),
        .mem_rd_a(mem_rd_a), .mem_RegWrite(mem_RegWrite), .mem_MemToReg(mem_MemToReg),
        .mem_MemWrite(mem_MemWrite),
        .wb_rd_a(wb_rd_a), .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg),
        .md_cancel(md_cancel),
        .ex_forward_a(ex_forward_a), .ex_forward_b(ex_forward_b),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .LoadStore(LoadStore),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cycles(perf_stall_cycles), .perf_md_stalls(perf_md_stalls),
`endif
        .md_busy(md_busy), .md_done(md_done), .md_rd_a(md_rd_a)
    );

    typedef struct {
        string       name;
        logic [1:0]  fa, fb;
        logic        st, ls, bz, dn;
        logic [4:0]  rd;
        logic [31:0] ps, pm;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          txn   = 0;
    logic [31:0] acc_s = 0;
    logic [31:0] acc_m = 0;

    task automatic clr();
        id_rs_a = 0; id_rt_a = 0; id_branch = 0; id_md = 0;
        ex_rs_a = 0; ex_rt_a = 0; ex_rd_a = 0; ex_RegWrite = 0; ex_MemToReg = 0; ex_md_start = 0;
        mem_rd_a = 0; mem_RegWrite = 0; mem_MemToReg = 0; mem_MemWrite = 0;
        wb_rd_a = 0; wb_RegWrite = 0; wb_MemToReg = 0; md_cancel = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ms: this cycle's stall is caused by the MDU scoreboard (raw or structural).
    task automatic expect_o(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                            input logic st, input logic ls, input logic bz, input logic dn,
                            input logic [4:0] rd, input logic ms);
        exp_t e;
        e.name = nm; e.fa = fa; e.fb = fb; e.st = st; e.ls = ls;
        e.bz = bz; e.dn = dn; e.rd = rd; e.ps = acc_s; e.pm = acc_m;
        q.push_back(e);
        if (rst) begin
            acc_s = 0; acc_m = 0;
        end else begin
            if (st) acc_s = acc_s + 1;
            if (ms) acc_m = acc_m + 1;
        end
    endtask

    task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] ex);
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL %s.%s got=%0h want=%0h", nm, f, act, ex);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            txn++;
            chk(e.name, "fwd_a", 32'(ex_forward_a), 32'(e.fa));
            chk(e.name, "fwd_b", 32'(ex_forward_b), 32'(e.fb));
            chk(e.name, "StallF", 32'(StallF), 32'(e.st));
            chk(e.name, "StallD", 32'(StallD), 32'(e.st));
            chk(e.name, "FlushE", 32'(FlushE), 32'(e.st));
            chk(e.name, "LoadStore", 32'(LoadStore), 32'(e.ls));
            chk(e.name, "md_busy", 32'(md_busy), 32'(e.bz));
            chk(e.name, "md_done", 32'(md_done), 32'(e.dn));
            chk(e.name, "md_rd_a", 32'(md_rd_a), 32'(e.rd));
`ifdef HAZARD_PERF_CNT_EN
            chk(e.name, "perf_stall", perf_stall_cycles, e.ps);
            chk(e.name, "perf_md", perf_md_stalls, e.pm);
`endif
            $display("txn %0d %s fa=%0d fb=%0d stall=%0b ls=%0b busy=%0b done=%0b rd=%0d",
                     txn, e.name, ex_forward_a, ex_forward_b, StallF, LoadStore,
                     md_busy, md_done, md_rd_a);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        clr();
        cyc();
        expect_o("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        rst = 1'b0;

        // MDU issue rd=5, four busy cycles, dependent ID read stalls until done
        clr(); ex_md_start = 1; ex_rd_a = 5;
        expect_o("t1_issue", 0, 0, 0, 0, 0, 0, 0, 0); cyc();
        for (int i = 0; i < 3; i++) begin
            clr(); id_rs_a = 5;
            expect_o("t1_raw", 0, 0, 1, 0, 1, 0, 5, 1); cyc();
        end
        clr(); id_rs_a = 5; ex_rs_a = 5; mem_rd_a = 5; mem_RegWrite = 1;
        ex_rt_a = 7; wb_rd_a = 7; wb_RegWrite = 1;
        expect_o("t2_mdu_fwd", 3, 1, 0, 0, 1, 1, 5, 0); cyc();
        clr(); ex_rs_a = 5; mem_rd_a = 5; mem_RegWrite = 1; wb_rd_a = 5; wb_RegWrite = 1;
        expect_o("t2_mem_fwd", 2, 0, 0, 0, 0, 0, 5, 0); cyc();
        clr(); ex_rs_a = 5; mem_rd_a = 5; mem_RegWrite = 1; mem_MemToReg = 1;
        wb_rd_a = 5; wb_RegWrite = 1;
        expect_o("t2_wb_fwd", 1, 0, 0, 0, 0, 0, 5, 0); cyc();

        // structural hazard, reissue on the done cycle
        clr(); ex_md_start = 1; ex_rd_a = 6;
        expect_o("t3_issue", 0, 0, 0, 0, 0, 0, 5, 0); cyc();
        for (int i = 0; i < 3; i++) begin
            clr(); id_md = 1;
            expect_o("t3_struct", 0, 0, 1, 0, 1, 0, 6, 1); cyc();
        end
        clr(); id_md = 1; ex_md_start = 1; ex_rd_a = 9;
        expect_o("t3_reissue", 0, 0, 0, 0, 1, 1, 6, 0); cyc();
        for (int i = 0; i < 3; i++) begin
            clr(); id_rs_a = 9;
            expect_o("t3_reload", 0, 0, 1, 0, 1, 0, 9, 1); cyc();
        end
        clr(); id_branch = 1; id_rs_a = 9;
        expect_o("t3_br_done", 0, 0, 1, 0, 1, 1, 9, 0); cyc();
        clr(); id_rs_a = 9;
        expect_o("t3_idle", 0, 0, 0, 0, 0, 0, 9, 0); cyc();

        // cancel mid-flight
        clr(); ex_md_start = 1; ex_rd_a = 5;
        expect_o("t4_issue", 0, 0, 0, 0, 0, 0, 9, 0); cyc();
        clr(); id_rs_a = 5;
        expect_o("t4_raw", 0, 0, 1, 0, 1, 0, 5, 1); cyc();
        clr(); id_rs_a = 5; md_cancel = 1;
        expect_o("t4_cancel", 0, 0, 1, 0, 1, 0, 5, 1); cyc();
        for (int i = 0; i < 4; i++) begin
            clr(); id_rs_a = 5;
            expect_o("t4_released", 0, 0, 0, 0, 0, 0, 5, 0); cyc();
        end
        // cancel on the final cycle suppresses md_done and MDU forwarding
        clr(); ex_md_start = 1; ex_rd_a = 3;
        expect_o("t4_issue3", 0, 0, 0, 0, 0, 0, 5, 0); cyc();
        for (int i = 0; i < 3; i++) begin
            clr();
            expect_o("t4_busy3", 0, 0, 0, 0, 1, 0, 3, 0); cyc();
        end
        clr(); md_cancel = 1; ex_rs_a = 3;
        expect_o("t4_cancel_last", 0, 0, 0, 0, 1, 0, 3, 0); cyc();
        clr(); ex_rs_a = 3;
        expect_o("t4_after", 0, 0, 0, 0, 0, 0, 3, 0); cyc();
        // cancel and issue together: issue wins
        clr(); ex_md_start = 1; ex_rd_a = 4;
        expect_o("t4_issue4", 0, 0, 0, 0, 0, 0, 3, 0); cyc();
        clr(); md_cancel = 1; ex_md_start = 1; ex_rd_a = 8;
        expect_o("t4_cancel_issue", 0, 0, 0, 0, 1, 0, 4, 0); cyc();
        for (int i = 0; i < 3; i++) begin
            clr();
            expect_o("t4_busy8", 0, 0, 0, 0, 1, 0, 8, 0); cyc();
        end
        clr(); id_md = 1;
        expect_o("t4_done8", 0, 0, 0, 0, 1, 1, 8, 0); cyc();
        clr();
        expect_o("t4_idle8", 0, 0, 0, 0, 0, 0, 8, 0); cyc();

        // load->store bypass and load-use
        clr(); mem_MemWrite = 1; mem_rd_a = 3; wb_MemToReg = 1; wb_rd_a = 3;
        expect_o("t5_loadstore", 0, 0, 0, 1, 0, 0, 8, 0); cyc();
        clr(); ex_MemToReg = 1; ex_rd_a = 4; id_rt_a = 4;
        expect_o("t5_load_use", 0, 0, 1, 0, 0, 0, 8, 0); cyc();
        clr(); ex_MemToReg = 1; ex_rd_a = 0;
        expect_o("t5_r0", 0, 0, 0, 0, 0, 0, 8, 0); cyc();
        clr(); mem_MemWrite = 1; mem_rd_a = 3; wb_MemToReg = 1; wb_rd_a = 3;
        ex_MemToReg = 1; ex_rd_a = 4; id_rs_a = 4;
        expect_o("t5_ls_masks_lu", 0, 0, 0, 1, 0, 0, 8, 0); cyc();
        clr(); mem_MemWrite = 1; wb_MemToReg = 1;
        expect_o("t5_ls_r0", 0, 0, 0, 0, 0, 0, 8, 0); cyc();
        clr(); id_branch = 1; id_rs_a = 2; mem_RegWrite = 1; mem_rd_a = 2;
        expect_o("t5_branch_mem", 0, 0, 1, 0, 0, 0, 8, 0); cyc();

        // reset mid-operation
        clr(); ex_md_start = 1; ex_rd_a = 5;
        expect_o("t6_issue", 0, 0, 0, 0, 0, 0, 8, 0); cyc();
        rst = 1'b1;
        clr(); id_rs_a = 5;
        expect_o("t6_rst_edge", 0, 0, 1, 0, 1, 0, 5, 1); cyc();
        clr(); id_rs_a = 5;
        expect_o("t6_in_rst", 0, 0, 0, 0, 0, 0, 0, 0); cyc();
        rst = 1'b0;
        clr(); id_rs_a = 5;
        expect_o("t6_after_rst", 0, 0, 0, 0, 0, 0, 0, 0); cyc();

        cyc();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
